// File: rtl/flash_port_arbiter_if.sv
// Requester, invalidate and flash-controller signals of the flash port arbiter.
interface flash_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ADDR_WIDTH = 24;

    // Instruction requester
    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_ready_o;
    logic [DATA_WIDTH-1:0] i_data_o;

    // Data requester
    logic                  d_req_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic                  d_ready_o;
    logic [DATA_WIDTH-1:0] d_data_o;

    // Line buffer control
    logic                  inval_i;

    // Flash controller
    logic                  fl_req_o;
    logic [ADDR_WIDTH-1:0] fl_addr_o;
    logic                  fl_write_o;
    logic                  fl_ready_i;
    logic [DATA_WIDTH-1:0] fl_data_i;

    // Arbiter side
    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_addr_i, inval_i, fl_ready_i, fl_data_i,
        output i_ready_o, i_data_o, d_ready_o, d_data_o, fl_req_o, fl_addr_o, fl_write_o
    );

    // Requesters and flash controller side
    modport master (
        output i_req_i, i_addr_i, d_req_i, d_addr_i, inval_i, fl_ready_i, fl_data_i,
        input  i_ready_o, i_data_o, d_ready_o, d_data_o, fl_req_o, fl_addr_o, fl_write_o
    );
endinterface

// File: rtl/flash_port_arbiter.sv
// Round-robin arbiter sharing one read-only flash port between an instruction
// and a data requester, with a one-word line buffer in front of the flash.
module flash_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                clk_i,
    input logic                reset_i,
    flash_port_arbiter_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = 24;
    localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t                state;
    port_t                 last_grant;
    port_t                 grant_q;
    logic                  buf_valid;
    logic [TAG_WIDTH-1:0]  buf_tag;
    logic [DATA_WIDTH-1:0] buf_data;

    port_t                 grant_c;
    logic                  any_req_c;
    logic [TAG_WIDTH-1:0]  grant_tag_c;
    logic                  hit_c;

    // Byte-offset bits of the requester addresses carry no information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_addr_i[1:0], bus.d_addr_i[1:0]};

    // The flash port is read-only from this block.
    assign bus.fl_write_o = 1'b0;

    // Round-robin pick and line-buffer lookup for the IDLE decision.
    always_comb begin
        any_req_c   = bus.i_req_i | bus.d_req_i;
        grant_c     = PORT_I;
        if (bus.i_req_i && bus.d_req_i) begin
            grant_c = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (bus.d_req_i) begin
            grant_c = PORT_D;
        end
        grant_tag_c = (grant_c == PORT_D) ? bus.d_addr_i[ADDR_WIDTH-1:2]
                                          : bus.i_addr_i[ADDR_WIDTH-1:2];
        // An invalidate in the lookup cycle forces a miss.
        hit_c       = buf_valid && !bus.inval_i && (buf_tag == grant_tag_c);
    end

    // Transaction FSM, line buffer and registered requester/flash outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state         <= IDLE;
            last_grant    <= PORT_I;
            grant_q       <= PORT_I;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            buf_data      <= '0;
            bus.fl_req_o  <= 1'b0;
            bus.fl_addr_o <= '0;
            bus.i_ready_o <= 1'b0;
            bus.i_data_o  <= '0;
            bus.d_ready_o <= 1'b0;
            bus.d_data_o  <= '0;
        end else begin
            if (bus.inval_i) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        grant_q    <= grant_c;
                        last_grant <= grant_c;
                        if (hit_c) begin
                            state <= RESP;
                            if (grant_c == PORT_D) begin
                                bus.d_ready_o <= 1'b1;
                                bus.d_data_o  <= buf_data;
                            end else begin
                                bus.i_ready_o <= 1'b1;
                                bus.i_data_o  <= buf_data;
                            end
                        end else begin
                            state         <= ISSUE;
                            bus.fl_req_o  <= 1'b1;
                            bus.fl_addr_o <= {grant_tag_c, 2'b00};
                        end
                    end
                end

                // Flash ready lags the request by a cycle, so it is ignored here.
                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.fl_ready_i) begin
                        state         <= RESP;
                        bus.fl_req_o  <= 1'b0;
                        bus.fl_addr_o <= '0;
                        buf_data      <= bus.fl_data_i;
                        buf_tag       <= bus.fl_addr_o[ADDR_WIDTH-1:2];
                        // A coincident invalidate still returns the word but leaves the buffer empty.
                        buf_valid     <= !bus.inval_i;
                        if (grant_q == PORT_D) begin
                            bus.d_ready_o <= 1'b1;
                            bus.d_data_o  <= bus.fl_data_i;
                        end else begin
                            bus.i_ready_o <= 1'b1;
                            bus.i_data_o  <= bus.fl_data_i;
                        end
                    end
                end

                RESP: begin
                    state         <= IDLE;
                    bus.i_ready_o <= 1'b0;
                    bus.i_data_o  <= '0;
                    bus.d_ready_o <= 1'b0;
                    bus.d_data_o  <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_port_arbiter.sv
// Scoreboard bench for flash_port_arbiter: reference model predicts responses,
// a negedge monitor compares them, a flash model answers fetches.
`timescale 1ns/1ps
module tb_flash_port_arbiter;
    localparam int unsigned DATA_WIDTH = 32;

    typedef struct packed {
        logic        port;   // 0 = instruction, 1 = data
        logic [31:0] data;
        logic        miss;
        logic [23:0] addr;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    flash_port_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    flash_port_arbiter #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    logic        inval_st = 1'b0;
    logic        inval_fl = 1'b0;
    logic        fl_ready = 1'b0;
    logic [31:0] fl_data  = '0;
    assign bus.inval_i    = inval_st | inval_fl;
    assign bus.fl_ready_i = fl_ready;
    assign bus.fl_data_i  = fl_data;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // Flash contents: default pattern, optionally overwritten per word.
    logic [31:0] mem_ovr [logic [21:0]];
    function automatic logic [31:0] rd_mem(input logic [21:0] w);
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Reference model state: one-word buffer and last grant.
    bit          m_valid = 1'b0;
    logic [21:0] m_tag   = '0;
    logic [31:0] m_data  = '0;
    bit          m_last  = 1'b0;
    bit          cap_inval_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // One granted access as seen by the model; pushes the expected response.
    task automatic model_access(input bit port, input logic [23:0] addr, input bit inv_lookup);
        exp_t e;
        logic [21:0] w;
        w = addr[23:2];
        if (inv_lookup) m_valid = 1'b0;
        e.port = port;
        e.addr = {w, 2'b00};
        if (m_valid && m_tag == w) begin
            e.miss = 1'b0;
            e.data = m_data;
        end else begin
            e.miss  = 1'b1;
            e.data  = rd_mem(w);
            m_data  = e.data;
            m_tag   = w;
            m_valid = !cap_inval_pending;
            cap_inval_pending = 1'b0;
        end
        m_last = port;
        sb.push_back(e);
    endtask

    // Flash controller model: ready after fl_lat WAIT cycles, optional early ready.
    int unsigned fl_lat = 1;
    bit          fl_glitch = 1'b0;
    bit          fl_cap_inval = 1'b0;
    int unsigned fl_cnt = 0;
    bit          fl_prev = 1'b0;
    always @(posedge clk_i) begin
        #1;
        fl_ready = 1'b0;
        fl_data  = '0;
        inval_fl = 1'b0;
        if (!bus.fl_req_o) begin
            fl_prev = 1'b0;
            fl_cnt  = 0;
        end else if (!fl_prev) begin
            fl_prev = 1'b1;
            fl_cnt  = 0;
            if (fl_glitch) begin
                fl_ready = 1'b1;
                fl_data  = 32'hBAD0_BAD0;
            end
        end else begin
            fl_cnt++;
            if (fl_cnt == fl_lat) begin
                fl_ready = 1'b1;
                fl_data  = rd_mem(bus.fl_addr_o[23:2]);
                if (fl_cap_inval) begin
                    inval_fl     = 1'b1;
                    fl_cap_inval = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every response and idle cycle against the scoreboard.
    bit   saw_fl = 1'b0;
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (!reset_i) begin
            saw_fl = 1'b0;
        end else begin
            if (bus.fl_req_o) begin
                saw_fl = 1'b1;
                if (sb.size() == 0) fail("fl_req_unexpected", "flash request with nothing outstanding");
                else check("fl_addr", 64'(bus.fl_addr_o), 64'(sb[0].addr));
            end
            if (bus.i_ready_o || bus.d_ready_o) begin
                if (sb.size() == 0) begin
                    fail("ready_unexpected", "response with nothing outstanding");
                end else begin
                    mon_e = sb.pop_front();
                    check("ready_port", 64'({bus.d_ready_o, bus.i_ready_o}), mon_e.port ? 64'd2 : 64'd1);
                    check("resp_data", 64'(mon_e.port ? bus.d_data_o : bus.i_data_o), 64'(mon_e.data));
                    check("other_port_data", 64'(mon_e.port ? bus.i_data_o : bus.d_data_o), 64'd0);
                    check("miss_flag", 64'(saw_fl), 64'(mon_e.miss));
                    check("fl_req_in_resp", 64'(bus.fl_req_o), 64'd0);
                    check("fl_write", 64'(bus.fl_write_o), 64'd0);
                end
                saw_fl = 1'b0;
            end else begin
                check("quiet_data", {bus.i_data_o, bus.d_data_o}, 64'd0);
            end
        end
    end

    // Runs one round: model prediction, then drive requests until all are served.
    task automatic do_round(input bit ri, input bit rd, input logic [23:0] ai, input logic [23:0] ad,
                            input bit late_d, input bit inv_req, input bit cap_inv,
                            output int lat_i, output int lat_d);
        bit first;
        bit pi;
        bit pd;
        bit late;
        late = late_d && ri && rd;
        cap_inval_pending = cap_inv;
        fl_cap_inval      = cap_inv;
        if (ri && rd) begin
            first = late ? 1'b0 : !m_last;
            model_access(first, first ? ad : ai, inv_req);
            model_access(!first, first ? ai : ad, 1'b0);
        end else if (ri) begin
            model_access(1'b0, ai, inv_req);
        end else begin
            model_access(1'b1, ad, inv_req);
        end
        bus.i_addr_i = ai;
        bus.d_addr_i = ad;
        bus.i_req_i  = ri;
        bus.d_req_i  = rd && !late;
        inval_st     = inv_req;
        pi = ri;
        pd = rd;
        lat_i = 0;
        lat_d = 0;
        for (int c = 1; c <= 400 && (pi || pd); c++) begin
            @(negedge clk_i);
            inval_st = 1'b0;
            if (pi && bus.i_ready_o) begin pi = 1'b0; bus.i_req_i = 1'b0; lat_i = c; end
            if (pd && bus.d_ready_o) begin pd = 1'b0; bus.d_req_i = 1'b0; lat_d = c; end
            if (late && c == 1 && pd) bus.d_req_i = 1'b1;
        end
        fl_cap_inval      = 1'b0;
        cap_inval_pending = 1'b0;
        if (pi || pd) begin
            fail("round_timeout", "no response within 400 cycles");
            finish_run();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_fl_req"},  64'(bus.fl_req_o),  64'd0);
        check({tag, "_fl_addr"}, 64'(bus.fl_addr_o), 64'd0);
        check({tag, "_i_ready"}, 64'(bus.i_ready_o), 64'd0);
        check({tag, "_d_ready"}, 64'(bus.d_ready_o), 64'd0);
        check({tag, "_i_data"},  64'(bus.i_data_o),  64'd0);
        check({tag, "_d_data"},  64'(bus.d_data_o),  64'd0);
    endtask

    task automatic inval_pulse();
        inval_st = 1'b1;
        @(negedge clk_i);
        inval_st = 1'b0;
        m_valid  = 1'b0;
    endtask

    initial begin
        #500_000;
        fail("watchdog", "simulation time limit reached");
        finish_run();
    end

    initial begin
        int li;
        int ld;
        bit ri;
        bit rd;
        logic [23:0] ai;
        logic [23:0] ad;

        reset_i      = 1'b0;
        bus.i_req_i  = 1'b0;
        bus.d_req_i  = 1'b0;
        bus.i_addr_i = '0;
        bus.d_addr_i = '0;
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        check("reset_fl_write", 64'(bus.fl_write_o), 64'd0);
        reset_i = 1'b1;
        @(negedge clk_i);

        // Instruction miss with a slow flash.
        mem_ovr[22'h41] = 32'hDEAD_BEEF;
        fl_lat = 70;
        do_round(1'b1, 1'b0, 24'h000104, 24'h0, 1'b0, 1'b0, 1'b0, li, ld);
        check("miss_latency", 64'(li), 64'd72);
        @(negedge clk_i);

        // Hit on the same word with different byte offset.
        fl_lat = 3;
        do_round(1'b1, 1'b0, 24'h000106, 24'h0, 1'b0, 1'b0, 1'b0, li, ld);
        check("hit_latency", 64'(li), 64'd1);
        @(negedge clk_i);

        // Invalidate then re-read misses.
        inval_pulse();
        do_round(1'b1, 1'b0, 24'h000104, 24'h0, 1'b0, 1'b0, 1'b0, li, ld);
        check("miss_after_inval_latency", 64'(li), 64'd5);
        @(negedge clk_i);

        // Invalidate coinciding with the capture: data returned, next read misses.
        do_round(1'b1, 1'b0, 24'h000104, 24'h0, 1'b0, 1'b1, 1'b1, li, ld);
        @(negedge clk_i);
        do_round(1'b1, 1'b0, 24'h000104, 24'h0, 1'b0, 1'b0, 1'b0, li, ld);
        check("miss_after_capture_inval", 64'(li), 64'd5);
        @(negedge clk_i);

        // Early flash ready during ISSUE must be ignored.
        fl_glitch = 1'b1;
        do_round(1'b0, 1'b1, 24'h0, 24'h000500, 1'b0, 1'b0, 1'b0, li, ld);
        check("ready_lag_latency", 64'(ld), 64'd5);
        fl_glitch = 1'b0;
        @(negedge clk_i);

        // Reset in WAIT aborts the access.
        fl_lat = 70;
        model_access(1'b0, 24'h000200, 1'b0);
        bus.i_addr_i = 24'h000200;
        bus.i_req_i  = 1'b1;
        repeat (10) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check_outputs_zero("reset_in_wait");
        bus.i_req_i = 1'b0;
        sb.delete();
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_last  = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);

        // Ties after reset: data first.
        fl_lat = 2;
        do_round(1'b1, 1'b1, 24'h000300, 24'h000400, 1'b0, 1'b0, 1'b0, li, ld);
        check("tie_after_reset_data_first", 64'(ld < li), 64'd1);
        @(negedge clk_i);
        do_round(1'b1, 1'b1, 24'h000308, 24'h000408, 1'b0, 1'b0, 1'b0, li, ld);
        @(negedge clk_i);

        // Randomized rounds.
        for (int r = 0; r < 300; r++) begin
            repeat (1 + $urandom_range(0, 2)) @(negedge clk_i);
            if ($urandom_range(0, 9) == 0) inval_pulse();
            if ($urandom_range(0, 9) == 0) mem_ovr[22'h40 + 22'($urandom_range(0, 7))] = $urandom;
            case ($urandom_range(0, 2))
                0:       begin ri = 1'b1; rd = 1'b0; end
                1:       begin ri = 1'b0; rd = 1'b1; end
                default: begin ri = 1'b1; rd = 1'b1; end
            endcase
            ai = 24'h000100 + 24'($urandom_range(0, 7) * 4) + 24'($urandom_range(0, 3));
            ad = 24'h000100 + 24'($urandom_range(0, 7) * 4) + 24'($urandom_range(0, 3));
            fl_lat    = $urandom_range(1, 5);
            fl_glitch = ($urandom_range(0, 3) == 0);
            do_round(ri, rd, ai, ad, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) == 0), li, ld);
        end
        fl_glitch = 1'b0;

        repeat (4) @(negedge clk_i);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        finish_run();
    end
endmodule

// File: doc/flash_port_arbiter.md
FLASH_PORT_ARBITER -- requirements
Module: flash_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of the flash data word and both requester data words.
REQ-002 SHALL have ports:
- clk_i  in  1  the single clock.
- reset_i  in  1  asynchronous, active-low reset.
- i_req_i  in  1  instruction-port read request.
- i_addr_i  in  24  instruction byte address.
- i_ready_o  out  1  instruction response pulse.
- i_data_o  out  DATA_WIDTH  instruction read data.
- d_req_i  in  1  data-port read request.
- d_addr_i  in  24  data byte address.
- d_ready_o  out  1  data response pulse.
- d_data_o  out  DATA_WIDTH  data read data.
- inval_i  in  1  invalidate the line buffer.
- fl_req_o  out  1  request to the flash controller.
- fl_addr_o  out  24  flash byte address.
- fl_write_o  out  1  flash write strobe, tied 0.
- fl_ready_i  in  1  flash controller ready.
- fl_data_i  in  DATA_WIDTH  flash read word.

Function
REQ-003 Requester handshake SHALL be: req_i held high until ready_o; ready_o is a single-cycle pulse; data_o is valid only in the ready_o cycle.
REQ-004 Requester addresses SHALL be word-aligned; bits [1:0] SHALL be ignored, and fl_addr_o[1:0] SHALL be 2'b00.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-006 In IDLE with at least one req_i high, the block SHALL grant one port, latch that port's address and go to RESP on a buffer hit or to ISSUE on a miss.
REQ-007 Arbitration SHALL be round-robin:
- On simultaneous requests, the port not granted last wins.
- After reset, the data port wins the first tie.
REQ-008 fl_req_o SHALL be high exactly in ISSUE and WAIT, and fl_addr_o SHALL hold the latched address in those states.
REQ-009 ISSUE SHALL last one cycle and ignore fl_ready_i, because the flash controller's ready lags fl_req_o by one cycle.
REQ-010 In WAIT, fl_ready_i high SHALL capture fl_data_i into the line buffer and the response register and move to RESP.
REQ-011 fl_req_o SHALL be low in the cycle after the fl_ready_i capture.
REQ-012 RESP SHALL last one cycle: it pulses the granted port's ready_o, drives its data_o from the response register and returns to IDLE.
REQ-013 The non-granted port's ready_o SHALL stay 0, and its data_o SHALL be 0 in every cycle.
REQ-014 Latency from req_i sampled in IDLE to ready_o SHALL be 1 cycle on a hit and 2 + (WAIT cycles) on a miss.
REQ-015 A request arriving while the FSM is not IDLE SHALL wait and be arbitrated in the next IDLE cycle.
REQ-016 The IDLE cycle SHALL be mandatory, so at most one response is produced per 2 cycles.
REQ-017 The line buffer SHALL hold one word, a 22-bit tag (address [23:2]) and a valid bit.
REQ-018 A hit SHALL require valid=1 and a tag equal to the granted address [23:2].
REQ-019 inval_i SHALL clear valid on the next edge.
REQ-020 If inval_i coincides with the WAIT capture, the word SHALL still be returned to the requester, but valid SHALL end 0.
REQ-021 If inval_i is high in IDLE, the lookup in that cycle SHALL be treated as a miss.
REQ-022 A requester dropping req_i before ready_o is illegal; the block SHALL complete the transaction regardless.
REQ-023 fl_write_o SHALL be constant 0.
REQ-024 The last-grant pointer SHALL update only on a grant in IDLE.

Reset
REQ-025 On reset_i low, the block SHALL asynchronously:
- enter IDLE;
- drive fl_req_o, i_ready_o and d_ready_o to 0;
- drive fl_addr_o, i_data_o and d_data_o to 0;
- clear buffer valid, tag and data to 0;
- set the last-grant pointer to instruction.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ready_o pulse; the dropped fl_req_o ends the flash access.
REQ-027 After reset release, the first edge with a request pending SHALL be treated as IDLE.

Verification
REQ-028 Instruction miss: i_req_i with address 0x000104, flash model gives ready after 70 cycles with data 0xDEADBEEF -> fl_addr_o=0x000104 in ISSUE/WAIT; i_ready_o pulses once with i_data_o=0xDEADBEEF; d_ready_o stays 0.
REQ-029 Hit: repeat a read of 0x000106 -> no fl_req_o; i_ready_o pulses 1 cycle after the request with data 0xDEADBEEF.
REQ-030 Tie after reset: i_req_i and d_req_i asserted together -> data port served first, then instruction, then alternating on the next tie.
REQ-031 Invalidate: pulse inval_i, then read 0x000104 -> fl_req_o asserted (miss); inval_i during WAIT still returns data but the next read of the same address misses.
REQ-032 Ready lag: fl_ready_i held high during ISSUE -> no capture; capture occurs only on fl_ready_i in WAIT.
REQ-033 Reset in WAIT: reset_i low -> all outputs 0 immediately; after release, a new request completes normally.
